// File: rtl/morse_sym_ctrl_if.sv
// rtl/morse_sym_ctrl_if.sv - recorder and letter-decoder signal bundle for the morse symbol sequencer
interface morse_sym_ctrl_if #(
  parameter int WID = 32
) ();

  // Recorder side: end-of-message level, five duration slots, restart pulse.
  logic             m_end;
  logic [5*WID-1:0] value;
  logic             rec_rst;

  // Decoder side: one assembled symbol over a valid/ready handshake.
  logic             sym_valid;
  logic             sym_ready;
  logic [2:0]       sym_len;
  logic [4:0]       sym_bits;
  logic             sym_err;

  // Status.
  logic             busy;

  // The sequencer itself.
  modport master (
    input  m_end,
    input  value,
    input  sym_ready,
    output sym_valid,
    output sym_len,
    output sym_bits,
    output sym_err,
    output rec_rst,
    output busy
  );

  // The environment around it (recorder plus decoder).
  modport slave (
    output m_end,
    output value,
    output sym_ready,
    input  sym_valid,
    input  sym_len,
    input  sym_bits,
    input  sym_err,
    input  rec_rst,
    input  busy
  );

endinterface

// File: rtl/morse_sym_ctrl.sv
// rtl/morse_sym_ctrl.sv - snapshots recorder slots, classifies dot/dash, presents one symbol
module morse_sym_ctrl #(
  parameter int WID      = 32,
  parameter int DASH_MIN = 8,
  parameter int MAX_CT   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  morse_sym_ctrl_if.master      bus
);

  localparam logic [WID-1:0] DASH_W = WID'(DASH_MIN);
  localparam logic [WID-1:0] MAX_W  = WID'(MAX_CT);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLASSIFY,
    PRESENT,
    CLEAR,
    WAIT_LOW
  } state_t;

  state_t         state_q;
  logic [WID-1:0] snap_q [5];
  logic [2:0]     idx_q;
  logic [2:0]     len_q;
  logic [4:0]     bits_q;
  logic           err_q;
  logic           stop_q;
  logic           valid_q;
  logic           rec_rst_q;
  logic           busy_q;

  // Classification result for the slot currently addressed by idx_q.
  logic [WID-1:0] slot_cur;
  logic [2:0]     len_d;
  logic [4:0]     bits_d;
  logic           err_d;
  logic           stop_d;

  // One slot per cycle: the first zero slot ends the symbol, later slots are ignored.
  always_comb begin
    slot_cur = snap_q[idx_q];
    len_d    = len_q;
    bits_d   = bits_q;
    err_d    = err_q;
    stop_d   = stop_q;
    if (!stop_q) begin
      if (slot_cur == '0) begin
        stop_d = 1'b1;
      end else begin
        len_d         = len_q + 3'd1;
        bits_d[idx_q] = (slot_cur >= DASH_W);
        if (slot_cur > MAX_W) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Sequencer FSM with all outputs registered; reset aborts any message in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < 5; i++) begin
        snap_q[i] <= '0;
      end
      idx_q     <= '0;
      len_q     <= '0;
      bits_q    <= '0;
      err_q     <= 1'b0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
      rec_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m_end) begin
            state_q <= LATCH;
            busy_q  <= 1'b1;
          end
        end

        LATCH: begin
          for (int i = 0; i < 5; i++) begin
            snap_q[i] <= bus.value[WID*i +: WID];
          end
          idx_q   <= '0;
          len_q   <= '0;
          bits_q  <= '0;
          err_q   <= 1'b0;
          stop_q  <= 1'b0;
          state_q <= CLASSIFY;
        end

        CLASSIFY: begin
          len_q  <= len_d;
          bits_q <= bits_d;
          stop_q <= stop_d;
          idx_q  <= idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            // An empty symbol is never a valid letter.
            err_q   <= err_d | (len_d == 3'd0);
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end else begin
            err_q <= err_d;
          end
        end

        PRESENT: begin
          if (bus.sym_ready) begin
            valid_q   <= 1'b0;
            rec_rst_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end

        CLEAR: begin
          rec_rst_q <= 1'b0;
          state_q   <= WAIT_LOW;
        end

        WAIT_LOW: begin
          // m_end is a level; wait for it to drop so one message fires only once.
          if (!bus.m_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          rec_rst_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sym_valid = valid_q;
  assign bus.sym_len   = len_q;
  assign bus.sym_bits  = bits_q;
  assign bus.sym_err   = err_q;
  assign bus.rec_rst   = rec_rst_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_morse_sym_ctrl.sv
// tb/tb_morse_sym_ctrl.sv - directed self-checking bench for morse_sym_ctrl
module tb_morse_sym_ctrl;

  localparam int WID = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  morse_sym_ctrl_if #(.WID(WID)) bus ();

  morse_sym_ctrl #(
    .WID      (WID),
    .DASH_MIN (8),
    .MAX_CT   (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [5*WID-1:0] pk(input int s0, input int s1, input int s2,
                                          input int s3, input int s4);
    return {WID'(s4), WID'(s3), WID'(s2), WID'(s1), WID'(s0)};
  endfunction

  task automatic check_out(input string tag, input logic [2:0] el, input logic [4:0] eb,
                           input logic ee);
    check({tag, ".len"},  32'(bus.sym_len),  32'(el));
    check({tag, ".bits"}, 32'(bus.sym_bits), 32'(eb));
    check({tag, ".err"},  32'(bus.sym_err),  32'(ee));
  endtask

  // One message: m_end seen at edge k, valid after k+6, handshake after `hold` stalled cycles.
  task automatic do_msg(input string tag, input logic [5*WID-1:0] v, input logic [2:0] el,
                        input logic [4:0] eb, input logic ee, input int hold, input bit drop);
    bus.value     = v;
    bus.m_end     = 1'b1;
    bus.sym_ready = (hold == 0);
    repeat (6) step();
    check({tag, ".novalid_k5"}, 32'(bus.sym_valid), 32'd0);
    check({tag, ".busy"},       32'(bus.busy),      32'd1);
    bus.value = pk(31, 31, 31, 31, 31);
    step();
    check({tag, ".valid"},      32'(bus.sym_valid), 32'd1);
    check({tag, ".rec_rst0"},   32'(bus.rec_rst),   32'd0);
    check_out(tag, el, eb, ee);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, ".hold_valid"}, 32'(bus.sym_valid), 32'd1);
        check({tag, ".hold_rst"},   32'(bus.rec_rst),   32'd0);
        check_out({tag, ".hold"}, el, eb, ee);
      end
      bus.sym_ready = 1'b1;
    end
    step();
    check({tag, ".valid_drop"}, 32'(bus.sym_valid), 32'd0);
    check({tag, ".rec_rst1"},   32'(bus.rec_rst),   32'd1);
    check_out({tag, ".kept"}, el, eb, ee);
    bus.sym_ready = 1'b0;
    step();
    check({tag, ".rec_rst_end"}, 32'(bus.rec_rst), 32'd0);
    check({tag, ".busy_wl"},     32'(bus.busy),    32'd1);
    if (drop) begin
      bus.m_end = 1'b0;
      step();
      check({tag, ".idle"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    int seen;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.m_end     = 1'b0;
    bus.value     = '0;
    bus.sym_ready = 1'b0;
    repeat (3) step();
    check("rst.valid",   32'(bus.sym_valid), 32'd0);
    check("rst.rec_rst", 32'(bus.rec_rst),   32'd0);
    check("rst.busy",    32'(bus.busy),      32'd0);
    check_out("rst", 3'd0, 5'd0, 1'b0);
    reset = 1'b0;
    step();

    do_msg("basic",  pk(3, 10, 2, 0, 0),   3'd3, 5'b00010, 1'b0, 0,  1'b1);
    do_msg("stall",  pk(9, 9, 9, 9, 9),    3'd5, 5'b11111, 1'b0, 10, 1'b1);
    do_msg("gap",    pk(4, 0, 12, 0, 0),   3'd1, 5'b00000, 1'b0, 0,  1'b1);
    do_msg("empty",  pk(0, 0, 0, 0, 0),    3'd0, 5'b00000, 1'b1, 0,  1'b1);
    do_msg("long",   pk(5, 30, 0, 0, 0),   3'd2, 5'b00010, 1'b1, 0,  1'b1);
    do_msg("bnd_ok", pk(24, 8, 7, 0, 0),   3'd3, 5'b00011, 1'b0, 0,  1'b1);
    do_msg("bnd_er", pk(8, 7, 24, 25, 1),  3'd5, 5'b01101, 1'b1, 0,  1'b1);
    do_msg("wide",   {32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'd7},
                                           3'd5, 5'b00010, 1'b1, 0,  1'b1);

    // Reset at edge k+4 aborts the message; m_end still high restarts it.
    bus.value     = pk(9, 0, 0, 0, 0);
    bus.m_end     = 1'b1;
    bus.sym_ready = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    check("abort.valid",   32'(bus.sym_valid), 32'd0);
    check("abort.rec_rst", 32'(bus.rec_rst),   32'd0);
    check("abort.busy",    32'(bus.busy),      32'd0);
    check_out("abort", 3'd0, 5'd0, 1'b0);
    reset = 1'b0;
    do_msg("restart", pk(9, 0, 0, 0, 0), 3'd1, 5'b00001, 1'b0, 0, 1'b0);

    // m_end held high through WAIT_LOW must not retrigger.
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sym_valid || bus.rec_rst) seen++;
    end
    check("waitlow.no_retrig", 32'(seen),     32'd0);
    check("waitlow.busy",      32'(bus.busy), 32'd1);
    bus.m_end = 1'b0;
    step();
    check("waitlow.idle", 32'(bus.busy), 32'd0);
    do_msg("again", pk(12, 3, 0, 0, 0), 3'd2, 5'b00001, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
